// File: rtl/id_front.sv
// Instruction-decode front end: holds the IF/ID latch, resolves branches and jumps
// early, and stalls fetch on load-use and branch-operand hazards.
module id_front (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NPCi,
  input  logic [31:0] IRi,
  input  logic [31:0] PCi,
  input  logic [31:0] rsVal,
  input  logic [31:0] rtVal,
  input  logic        exRegWrite,
  input  logic        exMemRead,
  input  logic [4:0]  exRd,
  output logic        cond,
  output logic [31:0] condNPC,
  output logic        stall,
  output logic [31:0] IRo,
  output logic [31:0] PCo,
  output logic [31:0] NPCo,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        idValid
);

  typedef enum logic [1:0] {RUN, HOLD1, HOLD2} state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, pc_q, npc_q;
  logic        valid_q;

  logic [5:0]  op;
  logic        is_beq, is_bne, is_j, is_jal, is_jr, is_branch, is_ctrl;
  logic        rs_hit, rt_hit, load_use, branch_haz, taken;
  logic [31:0] br_target, j_target;

  assign op        = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign is_beq    = (op == 6'h04);
  assign is_bne    = (op == 6'h05);
  assign is_j      = (op == 6'h02);
  assign is_jal    = (op == 6'h03);
  assign is_jr     = (op == 6'h00) && (ir_q[5:0] == 6'h08);
  assign is_branch = is_beq || is_bne;
  assign is_ctrl   = is_branch || is_j || is_jal || is_jr;

  // $0 is hardwired, so a producer targeting it never blocks a consumer.
  assign rs_hit = (exRd != 5'd0) && (exRd == rs);
  assign rt_hit = (exRd != 5'd0) && (exRd == rt);

  assign load_use   = !is_ctrl && exMemRead && (rs_hit || rt_hit);
  assign branch_haz = exRegWrite && ((is_branch && (rs_hit || rt_hit)) || (is_jr && rs_hit));

  assign br_target = npc_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign j_target  = {npc_q[31:28], ir_q[25:0], 2'b00};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_haz) begin
          stall   = 1'b1;
          state_d = exMemRead ? HOLD2 : HOLD1;
        end else if (load_use) begin
          stall = 1'b1;
        end
      end
      HOLD2:   begin stall = 1'b1; state_d = HOLD1; end
      HOLD1:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    taken   = is_j || is_jal || is_jr ||
              (is_beq && (rsVal == rtVal)) || (is_bne && (rsVal != rtVal));
    cond    = !stall && taken;
    condNPC = 32'h0;
    if (cond) begin
      if (is_branch)  condNPC = br_target;
      else if (is_jr) condNPC = rsVal;
      else            condNPC = j_target;
    end
  end

  // A stalled decode hands a bubble to EX while the latch keeps the instruction.
  assign IRo     = stall ? 32'h0 : ir_q;
  assign PCo     = stall ? 32'h0 : pc_q;
  assign NPCo    = stall ? 32'h0 : npc_q;
  assign idValid = !stall && valid_q;

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on clk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      ir_q    <= 32'h0;
      pc_q    <= 32'h0;
      npc_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!stall) begin
        if (cond) begin
          ir_q    <= 32'h0;
          pc_q    <= 32'h0;
          npc_q   <= 32'h0;
          valid_q <= 1'b0;
        end else begin
          ir_q    <= IRi;
          pc_q    <= PCi;
          npc_q   <= NPCi;
          valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_front.sv
// Directed bench for id_front: hand-computed expectations for redirects,
// load-use and branch hazards, flushing and reset.
module tb_id_front;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] NPCi, IRi, PCi, rsVal, rtVal;
  logic        exRegWrite, exMemRead;
  logic [4:0]  exRd;
  logic        cond, stall, idValid;
  logic [31:0] condNPC, IRo, PCo, NPCo;
  logic [4:0]  rs, rt;

  int vectors = 0;
  int miscompares = 0;

  id_front dut (
    .clk(clk), .rst(rst), .NPCi(NPCi), .IRi(IRi), .PCi(PCi),
    .rsVal(rsVal), .rtVal(rtVal), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .exRd(exRd), .cond(cond), .condNPC(condNPC), .stall(stall), .IRo(IRo),
    .PCo(PCo), .NPCo(NPCo), .rs(rs), .rt(rt), .idValid(idValid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] npc);
    IRi = ir; PCi = pc; NPCi = npc;
  endtask

  task automatic ex_idle();
    exRegWrite = 1'b0; exMemRead = 1'b0; exRd = 5'd0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    ex_idle();
    rsVal = 32'h0; rtVal = 32'h0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    fetch(32'h1022_0003, 32'h0000_0100, 32'h0000_0104);
    rst = 1'b0; ex_idle(); rsVal = 32'h5; rtVal = 32'h5;
    tick();
    fetch(32'h0800_0010, 32'h0000_0104, 32'h0000_0108);
    tick();
    rst = 1'b1;
    #1;
    if (cond !== 1'b0) begin miscompares++; $display("FAIL rst_cond got %b want 0", cond); end vectors++;
    if (condNPC !== 32'h0) begin miscompares++; $display("FAIL rst_condNPC got %h want 0", condNPC); end vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %b want 0", stall); end vectors++;
    if (IRo !== 32'h0) begin miscompares++; $display("FAIL rst_IRo got %h want 0", IRo); end vectors++;
    if (PCo !== 32'h0) begin miscompares++; $display("FAIL rst_PCo got %h want 0", PCo); end vectors++;
    if (NPCo !== 32'h0) begin miscompares++; $display("FAIL rst_NPCo got %h want 0", NPCo); end vectors++;
    if ({rs, rt} !== 10'h0) begin miscompares++; $display("FAIL rst_rs_rt got %h/%h want 0/0", rs, rt); end vectors++;
    if (idValid !== 1'b0) begin miscompares++; $display("FAIL rst_idValid got %b want 0", idValid); end vectors++;
  endtask

  task automatic test_beq_taken();
    apply_reset();
    fetch(32'h1022_0003, 32'h0000_0100, 32'h0000_0104);
    tick();
    fetch(32'hDEAD_BEEF, 32'h0000_0104, 32'h0000_0108);
    rsVal = 32'h5; rtVal = 32'h5;
    #1;
    if (cond !== 1'b1) begin miscompares++; $display("FAIL beq_cond got %b want 1", cond); end vectors++;
    if (condNPC !== 32'h0000_0110) begin miscompares++; $display("FAIL beq_target got %h want 00000110", condNPC); end vectors++;
    if (idValid !== 1'b1) begin miscompares++; $display("FAIL beq_idValid got %b want 1", idValid); end vectors++;
    if ({rs, rt} !== {5'd1, 5'd2}) begin miscompares++; $display("FAIL beq_rs_rt got %0d/%0d want 1/2", rs, rt); end vectors++;
    tick();
    #1;
    if (IRo !== 32'h0) begin miscompares++; $display("FAIL beq_flush_IRo got %h want 0", IRo); end vectors++;
    if (idValid !== 1'b0) begin miscompares++; $display("FAIL beq_flush_idValid got %b want 0", idValid); end vectors++;
    if (cond !== 1'b0) begin miscompares++; $display("FAIL beq_flush_cond got %b want 0", cond); end vectors++;
  endtask

  task automatic test_jump_bne();
    apply_reset();
    fetch(32'h0800_0010, 32'h4000_0000, 32'h4000_0004);
    tick();
    fetch(32'h0123_4567, 32'h4000_0004, 32'h4000_0008);
    #1;
    if (cond !== 1'b1) begin miscompares++; $display("FAIL j_cond got %b want 1", cond); end vectors++;
    if (condNPC !== 32'h4000_0040) begin miscompares++; $display("FAIL j_target got %h want 40000040", condNPC); end vectors++;
    tick();
    fetch(32'h1422_0003, 32'h0000_0040, 32'h0000_0044);
    tick();
    fetch(32'h0000_0000, 32'h0000_0044, 32'h0000_0048);
    rsVal = 32'h7; rtVal = 32'h7;
    #1;
    if (cond !== 1'b0) begin miscompares++; $display("FAIL bne_eq_cond got %b want 0", cond); end vectors++;
    if (condNPC !== 32'h0) begin miscompares++; $display("FAIL bne_eq_condNPC got %h want 0", condNPC); end vectors++;
    if (IRo !== 32'h1422_0003) begin miscompares++; $display("FAIL bne_IRo got %h want 14220003", IRo); end vectors++;
    rtVal = 32'h8;
    #1;
    if (condNPC !== 32'h0000_0050) begin miscompares++; $display("FAIL bne_ne_target got %h want 00000050", condNPC); end vectors++;
  endtask

  task automatic test_negative_offset();
    apply_reset();
    fetch(32'h1022_FFFF, 32'h0000_01FC, 32'h0000_0200);
    tick();
    rsVal = 32'h3; rtVal = 32'h3;
    #1;
    if (condNPC !== 32'h0000_01FC) begin miscompares++; $display("FAIL neg_target got %h want 000001fc", condNPC); end vectors++;
  endtask

  task automatic test_jr();
    apply_reset();
    fetch(32'h03E0_0008, 32'h0000_0600, 32'h0000_0604);
    tick();
    rsVal = 32'h1234_5678;
    #1;
    if ({cond, condNPC} !== {1'b1, 32'h1234_5678}) begin miscompares++; $display("FAIL jr_target got %b/%h want 1/12345678", cond, condNPC); end vectors++;
  endtask

  task automatic test_load_use();
    apply_reset();
    fetch(32'h0043_2020, 32'h0000_0300, 32'h0000_0304);
    tick();
    fetch(32'h0109_5020, 32'h0000_0304, 32'h0000_0308);
    exMemRead = 1'b1; exRegWrite = 1'b1; exRd = 5'd2;
    #1;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %b want 1", stall); end vectors++;
    if ({IRo, idValid} !== 33'h0) begin miscompares++; $display("FAIL lu_bubble got %h/%b want 0/0", IRo, idValid); end vectors++;
    tick();
    ex_idle();
    #1;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_release got %b want 0", stall); end vectors++;
    if ({IRo, PCo, NPCo} !== {32'h0043_2020, 32'h0000_0300, 32'h0000_0304}) begin
      miscompares++; $display("FAIL lu_held got %h/%h/%h want 00432020/00000300/00000304", IRo, PCo, NPCo);
    end vectors++;
    tick();
    #1;
    if (IRo !== 32'h0109_5020) begin miscompares++; $display("FAIL lu_next got %h want 01095020", IRo); end vectors++;
  endtask

  task automatic test_branch_after_load();
    apply_reset();
    fetch(32'h1065_0002, 32'h0000_0500, 32'h0000_0504);
    tick();
    fetch(32'hAAAA_0000, 32'h0000_0504, 32'h0000_0508);
    exMemRead = 1'b1; exRegWrite = 1'b1; exRd = 5'd3;
    rsVal = 32'h1; rtVal = 32'h2;
    #1;
    if ({stall, cond} !== 2'b10) begin miscompares++; $display("FAIL bl_c1 stall/cond got %b%b want 10", stall, cond); end vectors++;
    tick();
    ex_idle();
    #1;
    if ({stall, cond, idValid} !== 3'b100) begin miscompares++; $display("FAIL bl_c2 stall/cond/idValid got %b%b%b want 100", stall, cond, idValid); end vectors++;
    tick();
    rsVal = 32'h9; rtVal = 32'h9;
    #1;
    if ({stall, cond} !== 2'b01) begin miscompares++; $display("FAIL bl_c3 stall/cond got %b%b want 01", stall, cond); end vectors++;
    if (condNPC !== 32'h0000_050C) begin miscompares++; $display("FAIL bl_target got %h want 0000050c", condNPC); end vectors++;
    tick();
    #1;
    if ({stall, IRo, idValid} !== 34'h0) begin miscompares++; $display("FAIL bl_flush got %b/%h/%b want 0/0/0", stall, IRo, idValid); end vectors++;

    apply_reset();
    fetch(32'h1065_0002, 32'h0000_0500, 32'h0000_0504);
    tick();
    exMemRead = 1'b1; exRegWrite = 1'b1; exRd = 5'd0;
    #1;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL bl_r0_stall got %b want 0", stall); end vectors++;
  endtask

  task automatic test_branch_after_alu();
    apply_reset();
    fetch(32'h1065_0002, 32'h0000_0700, 32'h0000_0704);
    tick();
    exRegWrite = 1'b1; exRd = 5'd5;
    rsVal = 32'h4; rtVal = 32'h0;
    #1;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL ba_c1 stall got %b want 1", stall); end vectors++;
    tick();
    exRegWrite = 1'b1; exRd = 5'd5;
    rtVal = 32'h4;
    #1;
    if ({stall, cond, condNPC} !== {2'b01, 32'h0000_070C}) begin
      miscompares++; $display("FAIL ba_c2 got %b%b/%h want 01/0000070c", stall, cond, condNPC);
    end vectors++;
  endtask

  task automatic test_reset_during_hold();
    apply_reset();
    fetch(32'h1065_0002, 32'h0000_0800, 32'h0000_0804);
    tick();
    exMemRead = 1'b1; exRegWrite = 1'b1; exRd = 5'd3;
    tick();
    rst = 1'b0;
    ex_idle();
    tick();
    rst = 1'b1;
    rsVal = 32'h1; rtVal = 32'h1;
    #1;
    if ({stall, cond, IRo} !== 34'h0) begin miscompares++; $display("FAIL rh_abort got %b%b/%h want 00/0", stall, cond, IRo); end vectors++;
    fetch(32'h0043_2020, 32'h0000_0900, 32'h0000_0904);
    tick();
    #1;
    if ({stall, IRo, idValid} !== {1'b0, 32'h0043_2020, 1'b1}) begin
      miscompares++; $display("FAIL rh_resume got %b/%h/%b want 0/00432020/1", stall, IRo, idValid);
    end vectors++;
  endtask

  initial begin
    rst = 1'b0;
    fetch(32'h0, 32'h0, 32'h0);
    rsVal = 32'h0; rtVal = 32'h0;
    ex_idle();
    test_reset();
    test_beq_taken();
    test_jump_bne();
    test_negative_offset();
    test_jr();
    test_load_use();
    test_branch_after_load();
    test_branch_after_alu();
    test_reset_during_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
